// File: rtl/ci_initiator.sv
// ci_initiator: valid/ready front end that drives a multi-cycle custom-instruction slave with timeout and post-transaction clear.
// Optional CI_LATENCY_STATS_EN adds lat_last/lat_max done-latency outputs.
module ci_initiator #(
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              aclr_n,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [DATA_W-1:0] op_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_err,
    output logic              ci_clk_en,
    output logic              ci_start,
    output logic [DATA_W-1:0] ci_dataa,
    output logic              ci_reset,
    input  logic              ci_done,
`ifdef CI_LATENCY_STATS_EN
    input  logic [DATA_W-1:0] ci_result,
    output logic [15:0]       lat_last,
    output logic [15:0]       lat_max
`else
    input  logic [DATA_W-1:0] ci_result
`endif
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {CLR, IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state, state_nx;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] operand;
    logic              timeout;

    assign timeout  = cnt == CW'(TIMEOUT_CYC - 1);
    assign ci_dataa = operand;

    always_comb begin
        state_nx  = state;
        op_ready  = state == IDLE;
        ci_start  = state == ISSUE;
        ci_clk_en = state == ISSUE || state == WAIT;
        ci_reset  = state == CLR;
        res_valid = state == RESP;
        case (state)
            CLR:     state_nx = IDLE;
            IDLE:    state_nx = op_valid ? ISSUE : IDLE;
            ISSUE:   state_nx = WAIT;
            WAIT:    state_nx = (ci_done || timeout) ? RESP : WAIT;
            RESP:    state_nx = res_ready ? CLR : RESP;
            default: state_nx = CLR;
        endcase
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state    <= CLR;
            operand  <= '0;
            cnt      <= '0;
            res_data <= '0;
            res_err  <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && op_valid)
                operand <= op_data;
            cnt <= (state == WAIT) ? cnt + 1'b1 : '0;
            // done wins over timeout on the last allowed cycle
            if (state == WAIT && (ci_done || timeout)) begin
                res_data <= ci_done ? ci_result : '0;
                res_err  <= !ci_done;
            end
        end
    end

`ifdef CI_LATENCY_STATS_EN
    logic [31:0] lat_w;
    logic [15:0] lat16;

    assign lat_w = 32'(cnt) + 32'd1;
    assign lat16 = (lat_w > 32'hFFFF) ? 16'hFFFF : lat_w[15:0];

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            lat_last <= '0;
            lat_max  <= '0;
        end else if (state == WAIT && ci_done) begin
            lat_last <= lat16;
            lat_max  <= (lat16 > lat_max) ? lat16 : lat_max;
        end
    end
`endif

endmodule

// File: doc/ci_initiator.md
Name: ci_initiator

Overview:
- Drives the multi-cycle custom-instruction slave interface (clk_en/start/dataa in; done/result out) as the initiator.
- Upstream side accepts 32-bit float operands on a valid/ready channel. The block issues each operand to the slave (e.g. the cosine CORDIC unit), waits for done, and returns the result on a valid/ready channel.
- Guards against hung or sticky-done slaves with a timeout and a one-cycle slave clear after every transaction.
- Sits between a test/stream source and any CI-style accelerator in the design.

Parameters:
- DATA_W, 32, width of operand and result.
- TIMEOUT_CYC, 64, maximum WAIT cycles before declaring timeout (>=1).

Ports:
- clk  in  1  single clock.
- aclr_n  in  1  reset, asynchronous, active-low.
- op_valid  in  1  operand available.
- op_ready  out  1  initiator accepts operand this cycle.
- op_data  in  DATA_W  operand (float bits).
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  DATA_W  slave result (0 on timeout).
- res_err  out  1  result is a timeout, qualified by res_valid.
- ci_clk_en  out  1  to slave clk_en.
- ci_start  out  1  to slave start, one-cycle pulse.
- ci_dataa  out  DATA_W  to slave dataa.
- ci_reset  out  1  to slave aclr, active-high.
- ci_done  in  1  from slave done.
- ci_result  in  DATA_W  from slave result.

Behaviour:
- Reset is asynchronous and active-low on aclr_n; one clock, clk.
- Reset state is CLR. Reset values:
  - ci_reset=1.
  - All other outputs 0: op_ready, res_valid, res_err, res_data, ci_clk_en, ci_start, ci_dataa.
- The FSM is registered. Each output is a function of state and registers only. No combinational path from input to output.
- CLR:
  - ci_reset=1, everything else idle.
  - Always exactly one cycle, then IDLE.
  - Clears any sticky done in the slave.
- IDLE:
  - op_ready=1.
  - On op_valid: latch op_data into the operand register and go to ISSUE.
- ISSUE (one cycle):
  - ci_start=1, ci_clk_en=1, ci_dataa=operand register.
  - ci_done is ignored in this cycle.
  - Next state is WAIT; the wait counter is cleared to 0.
- WAIT:
  - ci_clk_en=1, ci_start=0, ci_dataa held.
  - Each cycle:
    - If ci_done=1: latch ci_result into res_data, res_err=0, go to RESP.
    - Else if counter==TIMEOUT_CYC-1: res_data=0, res_err=1, go to RESP.
    - Else counter+1.
  - done on the final allowed cycle takes priority over timeout.
  - Counter width is clog2(TIMEOUT_CYC+1).
- RESP:
  - res_valid=1; res_data and res_err are held stable; ci_clk_en=0.
  - On res_ready: go to CLR.
  - res_valid drops the cycle after the handshake.
- Latency:
  - Op accepted in cycle N; ci_start high in N+1.
  - With a slave whose done registers the cycle after start, done is sampled in N+2 and res_valid is high in N+3.
  - Throughput is one op per 5 cycles minimum (IDLE, ISSUE, WAIT, RESP, CLR) with zero back-pressure.
- Boundary conditions:
  - op_valid while not IDLE: not accepted (op_ready=0); the operand must be held by the source.
  - ci_done high outside WAIT: ignored.
  - res_ready held high continuously: each result lasts exactly one cycle.
  - aclr_n asserted mid-transaction: immediate return to CLR with reset values. The in-flight op is dropped with no result.
  - ci_dataa changes only on IDLE to ISSUE.

Optional Feature:
- Macro CI_LATENCY_STATS_EN.
- When defined, two extra outputs are added:
  - lat_last[15:0]: WAIT-cycle index of the most recent successful done, +1, so that done in the first WAIT cycle gives 1. Updated on entry to RESP.
  - lat_max[15:0]: running maximum of lat_last, saturating at 16'hFFFF, cleared only by reset.
- Both reset to 0. Timeouts update neither.
- When undefined: the ports and registers are absent; all other behaviour is identical.

Test Plan:
- Reset release with op_valid=1, op_data=32'h3F800000:
  - ci_reset=1 in the first cycle after release.
  - op_ready=1 in the second cycle.
  - ci_start pulses exactly one cycle with ci_dataa=32'h3F800000.
- Slave model asserts done 1 cycle after start with result 32'h3F0A5140 and res_ready=1:
  - res_valid pulses one cycle with res_data=32'h3F0A5140, res_err=0.
  - Total from op accept to res_valid is 3 cycles.
  - lat_last=1 if CI_LATENCY_STATS_EN.
- Slave never asserts done, TIMEOUT_CYC=64:
  - After 64 WAIT cycles, res_valid=1, res_err=1, res_data=0.
  - Then one ci_reset pulse.
  - lat_max unchanged.
- done on exactly WAIT cycle 64 with result 32'h12345678:
  - res_err=0, res_data=32'h12345678.
- res_ready held 0 for 10 cycles:
  - res_valid and res_data stay stable, op_ready stays 0, ci_clk_en=0.
  - On res_ready=1: CLR, then IDLE.
- Sticky-done slave (done stays 1) fed ops A=32'h40000000 then B=32'h40400000:
  - ci_reset pulses between the two transactions.
  - B's result is captured only from done sampled in WAIT after B's start, never from A's stale done.
  - aclr_n pulsed low during WAIT: all outputs return to reset values immediately.
